// File: rtl/pc_target_unit.sv
// Registered PC generator: sequential / PC-relative / JALR / return-address-stack targets, misaligned targets rejected.
// Latency: selected target appears on pc one clock later; pc_plus4 and pc_target are combinational.
// Backpressure: stall freezes pc, RAS and count and suppresses both fault pulses.
module pc_target_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              RAS_DEPTH   = 4,
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            push_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_target,
    output logic            misaligned,
    output logic            ras_underflow,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_REL = 2'b01;
    localparam logic [1:0] SRC_REG = 2'b10;
    localparam logic [1:0] SRC_RAS = 2'b11;

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;     // next free slot; top of stack is ras_ptr-1
    logic [CNT_W-1:0] ras_cnt;
    logic [PTR_W-1:0] top_idx;
    logic [XLEN-1:0]  ras_top;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  next_pc;
    logic             pop_req;
    logic             pop_empty;
    logic             target_bad;
    logic             do_push;
    logic             do_pop;

    assign pc_plus4  = pc + XLEN'(INSTR_BYTES);
    assign pc_target = pc + imm;
    assign jalr_sum  = rs1_data + imm;
    assign top_idx   = ras_ptr - PTR_W'(1);
    assign ras_top   = ras_mem[top_idx];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == DEPTH_CNT);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            SRC_REL: next_pc = pc_target;
            SRC_REG: next_pc = {jalr_sum[XLEN-1:1], 1'b0};
            SRC_RAS: if (!ras_empty) next_pc = ras_top;
            default: next_pc = pc_plus4;
        endcase
        pop_req    = (pc_src == SRC_RAS);
        pop_empty  = pop_req && ras_empty;
        target_bad = (pc_src != SRC_SEQ) && ((next_pc & ALIGN_MASK) != '0);
        // A rejected target cancels any stack traffic of the same cycle.
        do_pop     = !stall && !target_bad && pop_req && !ras_empty;
        do_push    = !stall && !target_bad && push_ret;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            misaligned    <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (stall) begin
            misaligned    <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (target_bad) begin
            misaligned    <= 1'b1;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= next_pc;
            misaligned    <= 1'b0;
            ras_underflow <= pop_empty;
            if (do_push && !do_pop) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                ras_ptr <= top_idx;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // Push+pop rewrites the top in place; a push on a full stack lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (do_push) ras_mem[do_pop ? top_idx : ras_ptr] <= pc_plus4;
    end

endmodule

// File: tb/tb_pc_target_unit.sv
// Bench for pc_target_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_target_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        push_ret = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] pc, pc_plus4, pc_target;
    logic        misaligned, ras_underflow, ras_empty, ras_full;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_mis;
    logic        m_uf;

    pc_target_unit #(.XLEN(32), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src), .imm(imm),
        .rs1_data(rs1_data), .push_ret(push_ret), .pc(pc), .pc_plus4(pc_plus4),
        .pc_target(pc_target), .misaligned(misaligned), .ras_underflow(ras_underflow),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0;
        m_ras.delete();
        m_mis = 1'b0;
        m_uf = 1'b0;
    endtask

    // Reference: the stack is a queue whose back is the top; overflow drops the front.
    task automatic model_step();
        logic [31:0] p4, nxt;
        int n;
        if (stall) begin
            m_mis = 1'b0;
            m_uf = 1'b0;
            return;
        end
        p4 = m_pc + 32'd4;
        n = m_ras.size();
        case (pc_src)
            2'd1: nxt = m_pc + imm;
            2'd2: nxt = (rs1_data + imm) & ~32'h1;
            2'd3: nxt = (n > 0) ? m_ras[n-1] : p4;
            default: nxt = p4;
        endcase
        if (pc_src != 2'd0 && nxt[1:0] != 2'b00) begin
            m_mis = 1'b1;
            m_uf = 1'b0;
            return;
        end
        m_mis = 1'b0;
        m_uf = (pc_src == 2'd3) && (n == 0);
        if (pc_src == 2'd3 && n > 0) void'(m_ras.pop_back());
        if (push_ret) begin
            m_ras.push_back(p4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = nxt;
    endtask

    task automatic apply(input logic st, input logic [1:0] src, input logic [31:0] im,
                         input logic [31:0] rs, input logic push);
        stall = st;
        pc_src = src;
        imm = im;
        rs1_data = rs;
        push_ret = push;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(0, 2'd0, 32'h0, 32'h0, 0);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras: empty=%b full=%b expected 1 0", ras_empty, ras_full); end
        checks++; if (misaligned !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: mis=%b uf=%b expected 0 0", misaligned, ras_underflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        apply(0, 2'd2, 32'h0, 32'h40, 1);
        tick();
        checks++; if (pc !== 32'h40 || ras_empty !== 1'b0) begin errors++; $display("FAIL pre_reset: pc=%h empty=%b expected 00000040 0", pc, ras_empty); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || ras_empty !== 1'b1) begin errors++; $display("FAIL async_reset: pc=%h empty=%b expected 00000000 1", pc, ras_empty); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        apply(0, 2'd0, 32'h0, 32'h0, 0);
        repeat (3) tick();
        checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL seq_after_reset: got %h expected %h", pc, 32'h0C); end
    endtask

    task automatic test_branch_wrap();
        apply(0, 2'd2, 32'h0, 32'h100, 0);
        tick();
        apply(0, 2'd1, 32'hFFFF_FFF0, 32'h0, 0);
        #1;
        checks++; if (pc_target !== 32'hF0) begin errors++; $display("FAIL branch_target_comb: got %h expected %h", pc_target, 32'hF0); end
        tick();
        checks++; if (pc !== 32'hF0) begin errors++; $display("FAIL branch_back: got %h expected %h", pc, 32'hF0); end
        apply(0, 2'd2, 32'h0, 32'hFFFF_FFFC, 0);
        tick();
        apply(0, 2'd0, 32'h8, 32'h0, 0);
        #1;
        checks++; if (pc_plus4 !== 32'h0 || pc_target !== 32'h4) begin errors++; $display("FAIL wrap_comb: plus4=%h target=%h expected 00000000 00000004", pc_plus4, pc_target); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_seq: got %h expected %h", pc, 32'h0); end
    endtask

    task automatic test_jalr();
        apply(0, 2'd2, 32'h1, 32'h203, 0);
        tick();
        checks++; if (pc !== 32'h204 || misaligned !== 1'b0) begin errors++; $display("FAIL jalr_clear_bit0: pc=%h mis=%b expected 00000204 0", pc, misaligned); end
        apply(0, 2'd2, 32'h2, 32'h200, 1);
        tick();
        checks++; if (pc !== 32'h204 || misaligned !== 1'b1) begin errors++; $display("FAIL jalr_misaligned: pc=%h mis=%b expected 00000204 1", pc, misaligned); end
        checks++; if (ras_empty !== (m_ras.size() == 0)) begin errors++; $display("FAIL misaligned_push_cancel: empty=%b expected %b", ras_empty, m_ras.size() == 0); end
        apply(0, 2'd0, 32'h0, 32'h0, 0);
        tick();
        checks++; if (pc !== 32'h208 || misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse_clear: pc=%h mis=%b expected 00000208 0", pc, misaligned); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_pop [4];
        exp_pop = '{32'h54, 32'h44, 32'h34, 32'h24};
        do_reset();
        apply(0, 2'd2, 32'h0, 32'h10, 0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            apply(0, 2'd2, 32'h0, 32'((k + 1) * 16), 1);
            tick();
        end
        checks++; if (ras_full !== 1'b1 || pc !== 32'h60) begin errors++; $display("FAIL ras_fill: full=%b pc=%h expected 1 00000060", ras_full, pc); end
        for (int k = 0; k < 4; k++) begin
            apply(0, 2'd3, 32'h0, 32'h0, 0);
            tick();
            checks++; if (pc !== exp_pop[k] || pc !== m_pc) begin errors++; $display("FAIL ras_pop%0d: got %h expected %h", k, pc, exp_pop[k]); end
        end
        apply(0, 2'd3, 32'h0, 32'h0, 0);
        tick();
        checks++; if (pc !== 32'h28 || ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin errors++; $display("FAIL ras_underflow: pc=%h uf=%b empty=%b expected 00000028 1 1", pc, ras_underflow, ras_empty); end
        apply(0, 2'd0, 32'h0, 32'h0, 0);
        tick();
        checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL uf_pulse_clear: got %b expected 0", ras_underflow); end
    endtask

    task automatic test_push_pop();
        do_reset();
        apply(0, 2'd2, 32'h0, 32'h7C, 0);
        tick();
        apply(0, 2'd2, 32'h0, 32'h200, 1);
        tick();
        apply(0, 2'd3, 32'h0, 32'h0, 1);
        tick();
        checks++; if (pc !== 32'h80 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin errors++; $display("FAIL push_pop: pc=%h empty=%b full=%b expected 00000080 0 0", pc, ras_empty, ras_full); end
        apply(0, 2'd3, 32'h0, 32'h0, 0);
        tick();
        checks++; if (pc !== 32'h204 || ras_empty !== 1'b1) begin errors++; $display("FAIL push_pop_top: pc=%h empty=%b expected 00000204 1", pc, ras_empty); end
        apply(0, 2'd3, 32'h0, 32'h0, 1);
        tick();
        checks++; if (pc !== 32'h208 || ras_underflow !== 1'b1 || ras_empty !== 1'b0) begin errors++; $display("FAIL push_pop_empty: pc=%h uf=%b empty=%b expected 00000208 1 0", pc, ras_underflow, ras_empty); end
        apply(0, 2'd3, 32'h0, 32'h0, 0);
        tick();
        checks++; if (pc !== 32'h208 + 32'h0 + 32'h0 && pc !== m_pc) begin errors++; $display("FAIL push_pop_empty_top: got %h expected %h", pc, m_pc); end
        checks++; if (pc !== 32'h208) begin errors++; $display("FAIL pop_pushed_ret: got %h expected %h", pc, 32'h208); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic        held_empty;
        apply(0, 2'd1, 32'h2, 32'h0, 0);
        tick();
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL pre_stall_mis: got %b expected 1", misaligned); end
        held = m_pc;
        held_empty = (m_ras.size() == 0);
        for (int k = 0; k < 3; k++) begin
            apply(1, 2'd1, (k == 2) ? 32'h42 : 32'h40 + 32'(k * 8), 32'h0, 1);
            #1;
            checks++; if (pc_target !== held + imm) begin errors++; $display("FAIL stall_comb%0d: got %h expected %h", k, pc_target, held + imm); end
            tick();
            checks++; if (pc !== held || ras_empty !== held_empty || misaligned !== 1'b0 || ras_underflow !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: pc=%h empty=%b mis=%b uf=%b expected %h %b 0 0", k, pc, ras_empty, misaligned, ras_underflow, held, held_empty);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] im, rs;
        for (int i = 0; i < 500; i++) begin
            im = ($urandom_range(0, 7) == 0) ? $urandom : (($urandom_range(0, 511) << 2) - 32'd1024);
            rs = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
            apply($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), im, rs, $urandom_range(0, 2) == 0);
            #1;
            checks++; if (pc_plus4 !== m_pc + 32'd4 || pc_target !== m_pc + imm) begin
                errors++; $display("FAIL rand_comb%0d: plus4=%h target=%h expected %h %h", i, pc_plus4, pc_target, m_pc + 32'd4, m_pc + imm);
            end
            tick();
            checks++; if (pc !== m_pc || misaligned !== m_mis || ras_underflow !== m_uf ||
                          ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == DEPTH)) begin
                errors++; $display("FAIL rand_state%0d: pc=%h mis=%b uf=%b empty=%b full=%b expected %h %b %b %b %b", i, pc, misaligned, ras_underflow,
                                   ras_empty, ras_full, m_pc, m_mis, m_uf, m_ras.size() == 0, m_ras.size() == DEPTH);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_branch_wrap();
        test_jalr();
        test_ras_overflow();
        test_push_pop();
        test_stall();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
